order_gen: RTL
==============

ORDER_GEN -- requirements
Module: order_gen

Interface
REQ-001 SHALL have parameter W, default 32, meaning price width.
REQ-002 SHALL have parameter QW, default 16, meaning quantity width; position is signed QW+2 bits.
REQ-003 SHALL have parameter IDW, default 16, meaning order-ID width.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  decision strobe from the strategy stage.
REQ-007 SHALL have ports buy, sell  input  1 each  decision flags, qualified by in_valid.
REQ-008 SHALL have ports bid_px0, ask_px0  input  W each  BBO, sampled with in_valid.
REQ-009 SHALL have ports qty  input  QW, max_pos  input  QW (unsigned limit), min_gap  input  8, enable  input  1  control-plane parameters.
REQ-010 SHALL have ports ord_valid  output  1, ord_ready  input  1, ord_side  output  1 (0=buy, 1=sell), ord_px  output  W, ord_qty  output  QW, ord_id  output  IDW  order stream to the TX encoder.
REQ-011 SHALL have ports fill_valid  input  1, fill_side  input  1, fill_qty  input  QW  execution feedback.
REQ-012 SHALL have ports position  output  QW+2 signed, drop_cnt  output  16, busy  output  1  status.

Function
REQ-013 SHALL implement FSM IDLE, CHECK, SEND, GAP; busy=1 in any state except IDLE.
REQ-014 In IDLE with in_valid: buy-only latches side 0, px=ask_px0; sell-only latches side 1, px=bid_px0; qty latched; next state CHECK.
REQ-015 In IDLE, in_valid with buy=sell=1 SHALL drop (drop_cnt+1) and stay IDLE; buy=sell=0 SHALL be ignored without counting.
REQ-016 CHECK (one cycle) SHALL pass iff enable=1 and, for buy, position+qty <= max_pos, or, for sell, position-qty >= -max_pos; pass -> SEND, fail -> drop_cnt+1, IDLE.
REQ-017 CHECK SHALL use the position value registered before any fill arriving in that same cycle.
REQ-018 In SEND, ord_valid=1 and all ord_* fields SHALL stay stable until ord_ready=1; enable deassertion SHALL NOT retract a presented order.
REQ-019 On handshake (ord_valid&ord_ready), ord_id SHALL increment modulo 2^IDW after the cycle; next state GAP with counter=min_gap, or IDLE if min_gap=0.
REQ-020 GAP SHALL count down one per cycle and return to IDLE on the cycle after the counter reaches 1.
REQ-021 in_valid with buy or sell set while not in IDLE SHALL be dropped and counted.
REQ-022 Latency: in_valid in cycle N SHALL give ord_valid in cycle N+2 at the earliest.
REQ-023 fill_valid SHALL update position every cycle in any state: +fill_qty for side 0, -fill_qty for side 1.
REQ-024 drop_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-025 Reset SHALL force state IDLE, ord_valid=0, ord_side=0, ord_px=0, ord_qty=0, ord_id=0, position=0, drop_cnt=0, busy=0, GAP counter=0.
REQ-026 Reset asserted during SEND SHALL discard the pending order without a handshake and without advancing ord_id.

Structure
REQ-027 Shared package order_pkg SHALL hold the side encoding, the FSM state enumeration and the default width constants.
REQ-028 Position accumulation SHALL be a sub-module pos_tracker (fill inputs -> signed position register).

Verification
REQ-029 max_pos=100, qty=10, ask=1000, buy strobe, ord_ready=1 -> ord_valid at N+2, side 0, px 1000, qty 10, id 0.
REQ-030 ord_ready held low 5 cycles -> ord_* fields stable throughout; second strobe in that window -> drop_cnt=1.
REQ-031 position=95 via fills, max_pos=100, qty=10, buy -> no ord_valid, drop_cnt+1; sell with bid=999 -> order px 999.
REQ-032 min_gap=3 -> strobes during the 3 GAP cycles dropped; a strobe on the first cycle back in IDLE accepted.
REQ-033 ord_id at 16'hFFFF, one handshake -> ord_id 0; buy=sell=1 strobe -> dropped, no order.
REQ-034 rst asserted while ord_valid=1 and ord_ready=0 -> next cycle ord_valid=0, ord_id unchanged from reset value 0, position 0.

Source files
------------

// File: rtl/order_pkg.sv
// Shared definitions for the order generator: side encoding, FSM states,
// default widths and the saturating drop-counter helper.
package order_pkg;

  localparam int unsigned PX_W_DEF  = 32;
  localparam int unsigned QTY_W_DEF = 16;
  localparam int unsigned ID_W_DEF  = 16;

  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } side_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Add a small increment to a 16-bit counter, sticking at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

endpackage

// File: rtl/order_gen_pos_tracker.sv
// Signed net position accumulated from execution fills.
module pos_tracker
  import order_pkg::*;
#(
  parameter int QW = QTY_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fill_valid,
  input  logic                 fill_side,
  input  logic [QW-1:0]        fill_qty,
  output logic signed [QW+1:0] position
);

  logic signed [QW+1:0] r_position;
  logic        [QW+1:0] w_fill_ext;

  assign w_fill_ext = {2'b00, fill_qty};
  assign position   = r_position;

  // Buy fills add to the position, sell fills subtract; every cycle, any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_position <= '0;
    end else if (fill_valid) begin
      if (fill_side == SIDE_BUY) begin
        r_position <= r_position + $signed(w_fill_ext);
      end else begin
        r_position <= r_position - $signed(w_fill_ext);
      end
    end
  end

endmodule

// File: rtl/order_gen.sv
// Order generator: turns strategy decisions into risk-checked, rate-limited
// orders for the TX encoder and tracks drops and net position.
module order_gen
  import order_pkg::*;
#(
  parameter int W   = PX_W_DEF,
  parameter int QW  = QTY_W_DEF,
  parameter int IDW = ID_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 buy,
  input  logic                 sell,
  input  logic [W-1:0]         bid_px0,
  input  logic [W-1:0]         ask_px0,
  input  logic [QW-1:0]        qty,
  input  logic [QW-1:0]        max_pos,
  input  logic [7:0]           min_gap,
  input  logic                 enable,
  output logic                 ord_valid,
  input  logic                 ord_ready,
  output logic                 ord_side,
  output logic [W-1:0]         ord_px,
  output logic [QW-1:0]        ord_qty,
  output logic [IDW-1:0]       ord_id,
  input  logic                 fill_valid,
  input  logic                 fill_side,
  input  logic [QW-1:0]        fill_qty,
  output logic signed [QW+1:0] position,
  output logic [15:0]          drop_cnt,
  output logic                 busy
);

  state_e         r_state;
  state_e         w_state_nxt;
  side_e          r_side;
  side_e          w_accept_side;
  logic [W-1:0]   r_px;
  logic [QW-1:0]  r_qty;
  logic [IDW-1:0] r_id;
  logic [7:0]     r_gap;
  logic [7:0]     w_gap_nxt;
  logic [15:0]    r_drop;
  logic           r_ord_valid;
  logic           r_busy;
  logic           w_accept;
  logic           w_id_inc;
  logic [1:0]     w_drop_inc;
  logic           w_strobe;
  logic           w_check_pass;
  logic           w_buy_ok;
  logic           w_sell_ok;

  // One extra bit of headroom so position +/- qty can never wrap.
  logic signed [QW+2:0] w_pos_ext;
  logic signed [QW+2:0] w_qty_ext;
  logic signed [QW+2:0] w_lim_ext;

  pos_tracker #(.QW(QW)) u_pos (
    .clk        (clk),
    .rst        (rst),
    .fill_valid (fill_valid),
    .fill_side  (fill_side),
    .fill_qty   (fill_qty),
    .position   (position)
  );

  assign w_strobe  = in_valid & (buy | sell);
  assign w_pos_ext = {position[QW+1], position};
  assign w_qty_ext = {3'b000, r_qty};
  assign w_lim_ext = {3'b000, max_pos};
  // The registered position is used, so a same-cycle fill does not affect the check.
  assign w_buy_ok     = (w_pos_ext + w_qty_ext) <= w_lim_ext;
  assign w_sell_ok    = (w_pos_ext - w_qty_ext) >= -w_lim_ext;
  assign w_check_pass = enable & ((r_side == SIDE_BUY) ? w_buy_ok : w_sell_ok);

  assign ord_valid = r_ord_valid;
  assign ord_side  = r_side;
  assign ord_px    = r_px;
  assign ord_qty   = r_qty;
  assign ord_id    = r_id;
  assign drop_cnt  = r_drop;
  assign busy      = r_busy;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, capture, drop and handshake decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_gap_nxt     = r_gap;
    w_accept      = 1'b0;
    w_accept_side = SIDE_BUY;
    w_id_inc      = 1'b0;
    // Any decision arriving while an order is in flight is lost.
    if ((r_state != ST_IDLE) && w_strobe) begin
      w_drop_inc = 2'd1;
    end else begin
      w_drop_inc = 2'd0;
    end
    case (r_state)
      ST_IDLE: begin
        if (in_valid && buy && sell) begin
          w_drop_inc = 2'd1;
        end else if (in_valid && buy) begin
          w_accept      = 1'b1;
          w_accept_side = SIDE_BUY;
          w_state_nxt   = ST_CHECK;
        end else if (in_valid && sell) begin
          w_accept      = 1'b1;
          w_accept_side = SIDE_SELL;
          w_state_nxt   = ST_CHECK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (w_check_pass) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_drop_inc  = w_drop_inc + 2'd1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (r_ord_valid && ord_ready) begin
          w_id_inc = 1'b1;
          if (min_gap == 8'd0) begin
            w_state_nxt = ST_IDLE;
            w_gap_nxt   = 8'd0;
          end else begin
            w_state_nxt = ST_GAP;
            w_gap_nxt   = min_gap;
          end
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_GAP: begin
        if (r_gap <= 8'd1) begin
          w_state_nxt = ST_IDLE;
          w_gap_nxt   = 8'd0;
        end else begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = r_gap - 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gap_nxt   = 8'd0;
      end
    endcase
  end

  // Order fields, ID, drop counter, gap counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_side      <= SIDE_BUY;
      r_px        <= '0;
      r_qty       <= '0;
      r_id        <= '0;
      r_gap       <= 8'd0;
      r_drop      <= 16'd0;
      r_ord_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_side <= w_accept_side;
        r_px   <= (w_accept_side == SIDE_BUY) ? ask_px0 : bid_px0;
        r_qty  <= qty;
      end
      if (w_id_inc) begin
        r_id <= r_id + {{(IDW-1){1'b0}}, 1'b1};
      end
      r_gap       <= w_gap_nxt;
      r_drop      <= sat_add16(r_drop, w_drop_inc);
      r_ord_valid <= (w_state_nxt == ST_SEND);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

endmodule
